mem_access: RTL and testbench

Memory-stage data access unit for the 5-stage MIPS pipeline. It sits on the M side of the EX/MEM pipeline register, consuming the latched instruction, ALU result (effective address) and store data. It decodes loads and stores, runs a req/ack handshake with the data memory bus, and stalls the pipeline until the access completes. It returns aligned, sign- or zero-extended load data to the MEM/WB register.

---
 rtl/mem_access.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit with a req/ack data bus handshake and pipeline stall.
// Build option: define MEM_MISALIGN_EXC_EN to trap misaligned accesses on adelM/adesM.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        stallM,
  output logic [31:0] ReadDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef MEM_MISALIGN_EXC_EN
  ,
  output logic        adelM,
  output logic        adesM
`endif
);

  // state | meaning
  // IDLE  | evaluate instrM; a memory op loads the bus registers and stalls
  // WAIT  | request on the bus, waiting for mem_ack
  // DONE  | access complete, ReadDataM valid, pipeline advances
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  ld_op_q, ld_op_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [31:0] read_data_q, read_data_d;

  logic [5:0]  opcode;
  logic [1:0]  a;
  logic        is_load, is_store, sz_byte, sz_half;
  logic        misalign, trap, go;
  logic [1:0]  off_eff;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic        unused_bits;

  assign opcode = instrM[31:26];
  assign a      = ALUOutM[1:0];

  always_comb begin : decode
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_byte  = 1'b0;
    sz_half  = 1'b0;
    case (opcode)
      OP_LB, OP_LBU: begin is_load = 1'b1;  sz_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  sz_half = 1'b1; end
      OP_LW:         begin is_load = 1'b1;                  end
      OP_SB:         begin is_store = 1'b1; sz_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1;                 end
      default:       ;
    endcase
  end

  // Offset is forced to natural alignment; misalign flags what was dropped.
  always_comb begin : store_fmt
    misalign  = 1'b0;
    off_eff   = 2'b00;
    be_new    = 4'b1111;
    wdata_new = WriteDataM;
    if (sz_byte) begin
      off_eff = a;
    end else if (sz_half) begin
      off_eff  = {a[1], 1'b0};
      misalign = a[0];
    end else begin
      misalign = (a != 2'b00);
    end
    if (is_store && sz_byte) begin
      be_new    = 4'b0001 << a;
      wdata_new = {4{WriteDataM[7:0]}};
    end else if (is_store && sz_half) begin
      be_new    = a[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{WriteDataM[15:0]}};
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  logic adel_q, adel_d;
  logic ades_q, ades_d;
  assign trap        = misalign;
  assign unused_bits = ^instrM[25:0];
  assign adelM       = adel_q;
  assign adesM       = ades_q;
`else
  assign trap        = 1'b0;
  assign unused_bits = ^{instrM[25:0], misalign};
`endif

  assign go = (state_q == ST_IDLE) && (is_load || is_store) && !trap;

  always_comb begin : load_fmt
    lane_b = mem_rdata[{ld_off_q, 3'b000} +: 8];
    lane_h = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_op_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'd0, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'd0, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin : next_state
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    ld_op_d     = ld_op_q;
    ld_off_d    = ld_off_q;
    read_data_d = read_data_q;
`ifdef MEM_MISALIGN_EXC_EN
    adel_d      = 1'b0;
    ades_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d     = ST_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = {ALUOutM[31:2], 2'b00};
          mem_be_d    = be_new;
          mem_wdata_d = wdata_new;
          ld_op_d     = opcode[2:0];
          ld_off_d    = off_eff;
        end
`ifdef MEM_MISALIGN_EXC_EN
        adel_d = is_load && misalign;
        ades_d = is_store && misalign;
`endif
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) read_data_d = load_ext;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      ld_op_q     <= 3'd0;
      ld_off_q    <= 2'd0;
      read_data_q <= 32'd0;
`ifdef MEM_MISALIGN_EXC_EN
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      ld_op_q     <= ld_op_d;
      ld_off_q    <= ld_off_d;
      read_data_q <= read_data_d;
`ifdef MEM_MISALIGN_EXC_EN
      adel_q      <= adel_d;
      ades_q      <= ades_d;
`endif
    end
  end

  // Stall is combinational so the pipeline freezes in the detection cycle.
  assign stallM    = rst & (go | (state_q == ST_WAIT));
  assign ReadDataM = read_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and random load/store traffic against an arithmetic reference model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrM, ALUOutM, WriteDataM, mem_rdata;
  logic        mem_ack;
  logic        stallM, mem_req, mem_we;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
`ifdef MEM_MISALIGN_EXC_EN
  logic        adelM, adesM;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd_model;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .instrM(instrM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .stallM(stallM), .ReadDataM(ReadDataM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MEM_MISALIGN_EXC_EN
    , .adelM(adelM), .adesM(adesM)
`endif
  );

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;
  logic [5:0] mem_ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_load_op(input logic [5:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  function automatic bit is_mem_op(input logic [5:0] op);
    return is_load_op(op) || op == SB || op == SH || op == SW;
  endfunction

  function automatic int op_size(input logic [5:0] op);
    if (op == LW || op == SW) return 4;
    if (op == LH || op == LHU || op == SH) return 2;
    return 1;
  endfunction

  function automatic int eff_off(input logic [5:0] op, input logic [31:0] addr);
    int sz = op_size(op);
    return (int'(addr % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int sz = op_size(op);
    logic [31:0] v = rd >> (8 * eff_off(op, addr));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (op == LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (op == LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_be(input logic [5:0] op, input logic [31:0] addr);
    int m;
    if (is_load_op(op)) return 32'hF;
    m = ((1 << op_size(op)) - 1) << eff_off(op, addr);
    return 32'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] wd);
    if (op_size(op) == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (op_size(op) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [5:0] rand_nonmem();
    logic [5:0] op;
    do op = 6'($urandom_range(0, 63)); while (is_mem_op(op));
    return op;
  endfunction

  // Entered and left at 1 time unit after a rising edge, with the FSM in IDLE.
  task automatic mem_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int nwait, output int stalls);
    bit ld = is_load_op(op);
    instrM     = {op, 26'($urandom)};
    ALUOutM    = addr;
    WriteDataM = wd;
    mem_ack    = 1'b0;
    #1;
    stalls = 0;
    if (stallM) stalls++;
    chk("req_idle", 32'(mem_req), 32'd0);
    for (int i = 1; i <= nwait; i++) begin
      @(posedge clk); #1;
      if (stallM) stalls++;
      chk("req_wait", 32'(mem_req), 32'd1);
      chk("we_wait", 32'(mem_we), 32'(!ld));
      chk("addr_wait", mem_addr, addr & ~32'd3);
      chk("be_wait", 32'(mem_be), ref_be(op, addr));
      if (!ld) chk("wdata_wait", mem_wdata, ref_wdata(op, wd));
      chk("rdata_hold", ReadDataM, rd_model);
      mem_rdata = (i == nwait) ? rd : $urandom;
      mem_ack   = (i == nwait);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    if (stallM) stalls++;
    if (ld) rd_model = ref_load(op, addr, rd);
    chk("req_done", 32'(mem_req), 32'd0);
    chk("rdata_done", ReadDataM, rd_model);
    chk("stall_cnt", 32'(stalls), 32'(nwait + 1));
    instrM    = {rand_nonmem(), 26'($urandom)};
    mem_rdata = $urandom;
    @(posedge clk); #1;
    chk("req_after", 32'(mem_req), 32'd0);
    chk("stall_after", 32'(stallM), 32'd0);
  endtask

  initial begin
    int s1, s2;
    logic [5:0]  op;
    logic [31:0] addr;
    rst = 1'b0; instrM = 32'd0; ALUOutM = 32'd0; WriteDataM = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0; rd_model = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_stall", 32'(stallM), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    mem_op(LW, 32'h100, 32'h0, 32'hDEADBEEF, 2, s1);
    chk("lw_const", ReadDataM, 32'hDEADBEEF);
    chk("lw_stall3", 32'(s1), 32'd3);
    mem_op(LB, 32'h203, 32'h0, 32'h80112233, 1, s1);
    chk("lb_const", ReadDataM, 32'hFFFFFF80);
    mem_op(LBU, 32'h203, 32'h0, 32'h80112233, 3, s1);
    chk("lbu_const", ReadDataM, 32'h00000080);
    mem_op(SH, 32'h42, 32'h1234ABCD, 32'h0, 1, s1);
    chk("sh_rdata_kept", ReadDataM, 32'h00000080);

    // Stray ack while idle must be ignored.
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stray_req", 32'(mem_req), 32'd0);
    chk("stray_stall", 32'(stallM), 32'd0);
    chk("stray_rdata", ReadDataM, rd_model);

    mem_op(SW, 32'h500, 32'hCAFEF00D, 32'h0, 1, s1);
    mem_op(SB, 32'h603, 32'h000000A5, 32'h0, 1, s2);
    chk("b2b_stall", 32'(s1 + s2), 32'd4);

`ifdef MEM_MISALIGN_EXC_EN
    instrM = {LW, 26'd0}; ALUOutM = 32'h101; #1;
    chk("mis_stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    instrM = {rand_nonmem(), 26'd0};
    chk("mis_adel", 32'(adelM), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    chk("mis_adel_end", 32'(adelM), 32'd0);
`else
    mem_op(LW, 32'h101, 32'h0, 32'h13579BDF, 2, s1);
    chk("mis_lw_trunc", ReadDataM, 32'h13579BDF);
`endif

    // Reset in the middle of a wait.
    instrM = {LW, 26'd0}; ALUOutM = 32'h300;
    @(posedge clk); #1;
    chk("mid_req", 32'(mem_req), 32'd1);
    @(negedge clk); rst = 1'b0; instrM = {rand_nonmem(), 26'd0}; #1;
    rd_model = 32'd0;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_be", 32'(mem_be), 32'd0);
    chk("mid_rst_rdata", ReadDataM, 32'd0);
    chk("mid_rst_stall", 32'(stallM), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall", 32'(stallM), 32'd0);
    chk("post_rst_req", 32'(mem_req), 32'd0);

    for (int n = 0; n < 40; n++) begin
      op   = mem_ops[$urandom_range(0, 7)];
      addr = $urandom;
`ifdef MEM_MISALIGN_EXC_EN
      addr = addr & ~32'(op_size(op) - 1);
`endif
      mem_op(op, addr, $urandom, $urandom, $urandom_range(1, 4), s1);
      if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("gap_rdata", ReadDataM, rd_model);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
